// File: rtl/idu_stage.sv
// ---------------------------------------------------------------------------
// idu_stage -- RV-style instruction decode stage with an output register
// and a one-entry skid buffer.
//
// Each raw instruction is decoded combinationally into a bundle of register
// indices, immediates, function bits and a one-hot type. The bundle is then
// registered. The output register presents the bundle downstream. The skid
// register catches the one instruction that can arrive while the output is
// stalled, because in_ready is registered and so lags the stall by a cycle.
//
// Ports
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   flush              drop every buffered instruction at the next edge
//   in_valid/in_ready  upstream handshake; in_ready = skid empty (registered)
//   in_inst, in_pc     raw instruction and its address
//   out_valid/out_ready downstream handshake
//   out_pc             PC of the presented bundle
//   d0en, s1en, s2en   rd / rs1 / rs2 valid
//   d0imm              rd (zero-extended) or the S/B immediate
//   s1                 rs1 (zero-extended) or 0
//   s2imm              rs2 (zero-extended) or the I/U/J immediate
//   fun                {funct3, funct7}
//   itype              one-hot {J, U, B, S, I, R}
//   illegal            unsupported encoding
// All out_* read as 0 while out_valid is 0.
// ---------------------------------------------------------------------------
module idu_stage #(
  parameter int WIDTH    = 32,
  parameter int INST_MAX = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INST_MAX-1:0] in_inst,
  input  logic [WIDTH-1:0]    in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_pc,
  output logic                d0en,
  output logic                s1en,
  output logic                s2en,
  output logic [WIDTH-1:0]    d0imm,
  output logic [WIDTH-1:0]    s1,
  output logic [WIDTH-1:0]    s2imm,
  output logic [9:0]          fun,
  output logic [5:0]          itype,
  output logic                illegal
);

  // Bundle layout: {pc, d0en, s1en, s2en, d0imm, s1, s2imm, fun, itype, illegal}
  localparam int BW = 4*WIDTH + 20;

  // ---------------- combinational decode ----------------
  logic [6:0]       opcode;
  logic             is_r, is_i, is_env, is_s, is_b, is_u, is_j, is_any;
  logic             dec_d0en, dec_s1en, dec_s2en;
  logic [WIDTH-1:0] dec_d0imm, dec_s1, dec_s2imm;
  logic [WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [WIDTH-1:0] rd_z, rs1_z, rs2_z;
  logic             sgn;

  assign opcode = in_inst[6:0];
  assign sgn    = in_inst[31];

  assign imm_i = {{(WIDTH-12){sgn}}, in_inst[31:20]};
  assign imm_s = {{(WIDTH-12){sgn}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{(WIDTH-13){sgn}}, in_inst[31], in_inst[7], in_inst[30:25],
                  in_inst[11:8], 1'b0};
  assign imm_j = {{(WIDTH-21){sgn}}, in_inst[31], in_inst[19:12], in_inst[20],
                  in_inst[30:21], 1'b0};

  // The U immediate already fills 32 bits, so it only needs extension above that.
  generate
    if (WIDTH > 32) begin : g_u_ext
      assign imm_u = {{(WIDTH-32){sgn}}, in_inst[31:12], 12'b0};
    end else begin : g_u_noext
      assign imm_u = {in_inst[31:12], 12'b0};
    end
  endgenerate

  assign rd_z  = {{(WIDTH-5){1'b0}}, in_inst[11:7]};
  assign rs1_z = {{(WIDTH-5){1'b0}}, in_inst[19:15]};
  assign rs2_z = {{(WIDTH-5){1'b0}}, in_inst[24:20]};

  always_comb begin
    is_r   = 1'b0;
    is_i   = 1'b0;
    is_env = 1'b0;
    is_s   = 1'b0;
    is_b   = 1'b0;
    is_u   = 1'b0;
    is_j   = 1'b0;
    case (opcode)
      7'b0110011:                         is_r   = 1'b1;
      7'b0010011, 7'b0000011, 7'b1100111: is_i   = 1'b1;
      7'b1110011:                         is_env = 1'b1;
      7'b0100011:                         is_s   = 1'b1;
      7'b1100011:                         is_b   = 1'b1;
      7'b0110111, 7'b0010111:             is_u   = 1'b1;
      7'b1101111:                         is_j   = 1'b1;
      default: ;
    endcase
  end

  // Every listed opcode ends in 2'b11, so an unknown opcode also covers the
  // compressed-encoding case; no separate check on inst[1:0] is needed.
  assign is_any = is_r | is_i | is_env | is_s | is_b | is_u | is_j;

  assign dec_d0en = is_any & ~is_b & ~is_s & ~is_env;
  assign dec_s1en = is_any & ~is_j & ~is_u & ~is_env;
  assign dec_s2en = is_r | is_s | is_b;

  always_comb begin
    dec_d0imm = '0;
    if (dec_d0en)  dec_d0imm = rd_z;
    else if (is_s) dec_d0imm = imm_s;
    else if (is_b) dec_d0imm = imm_b;

    dec_s1 = dec_s1en ? rs1_z : '0;

    dec_s2imm = '0;
    if (dec_s2en)             dec_s2imm = rs2_z;
    else if (is_i || is_env)  dec_s2imm = imm_i;
    else if (is_u)            dec_s2imm = imm_u;
    else if (is_j)            dec_s2imm = imm_j;
  end

  logic [BW-1:0] dec_bundle;
  assign dec_bundle = {in_pc, dec_d0en, dec_s1en, dec_s2en, dec_d0imm, dec_s1,
                       dec_s2imm, in_inst[14:12], in_inst[31:25],
                       {is_j, is_u, is_b, is_s, is_i | is_env, is_r}, ~is_any};

  // ---------------- output register + skid ----------------
  logic          out_valid_reg, out_valid_next;
  logic          skid_valid_reg, skid_valid_next;
  logic          in_ready_reg;
  logic [BW-1:0] out_bundle_reg, skid_bundle_reg;
  logic          in_fire, out_free;
  logic          load_out_from_skid, load_out_from_in, load_skid;

  assign in_fire  = in_valid & in_ready_reg;
  // The output slot can take new data if it is empty or draining this edge.
  assign out_free = ~out_valid_reg | out_ready;

  always_comb begin
    out_valid_next     = out_valid_reg;
    skid_valid_next    = skid_valid_reg;
    load_out_from_skid = 1'b0;
    load_out_from_in   = 1'b0;
    load_skid          = 1'b0;
    if (flush) begin
      out_valid_next  = 1'b0;
      skid_valid_next = 1'b0;
    end else if (out_free) begin
      if (skid_valid_reg) begin
        // in_ready is low while the skid is full, so no accept can collide.
        load_out_from_skid = 1'b1;
        out_valid_next     = 1'b1;
        skid_valid_next    = 1'b0;
      end else if (in_fire) begin
        load_out_from_in = 1'b1;
        out_valid_next   = 1'b1;
      end else begin
        out_valid_next = 1'b0;
      end
    end else if (in_fire) begin
      load_skid       = 1'b1;
      skid_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
      in_ready_reg   <= 1'b1;
    end else begin
      out_valid_reg  <= out_valid_next;
      skid_valid_reg <= skid_valid_next;
      in_ready_reg   <= ~skid_valid_next;
    end
  end

  // Payload carries no reset; the valid bits alone say whether it means anything.
  always_ff @(posedge clk) begin
    if (load_out_from_skid)    out_bundle_reg <= skid_bundle_reg;
    else if (load_out_from_in) out_bundle_reg <= dec_bundle;
    if (load_skid)             skid_bundle_reg <= dec_bundle;
  end

  // Mask the stale payload so every output reads 0 while nothing is presented.
  logic [BW-1:0] out_gated;
  generate
    for (genvar gi = 0; gi < BW; gi++) begin : g_gate
      assign out_gated[gi] = out_bundle_reg[gi] & out_valid_reg;
    end
  endgenerate

  assign {out_pc, d0en, s1en, s2en, d0imm, s1, s2imm, fun, itype, illegal} = out_gated;
  assign out_valid = out_valid_reg;
  assign in_ready  = in_ready_reg;

endmodule

// File: tb/tb_idu_stage.sv
// ---------------------------------------------------------------------------
// tb_idu_stage -- directed bench for idu_stage. A 32-bit instance carries
// the decode, stall, flush and reset vectors; a 64-bit instance checks the
// U-immediate sign extension.
// ---------------------------------------------------------------------------
module tb_idu_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc;
  logic        d0en, s1en, s2en;
  logic [31:0] d0imm, s1, s2imm;
  logic [9:0]  fun;
  logic [5:0]  itype;
  logic        illegal;

  logic        w_in_valid = 1'b0;
  logic        w_in_ready;
  logic [31:0] w_in_inst = '0;
  logic [63:0] w_in_pc = '0;
  logic        w_out_valid;
  logic [63:0] w_out_pc;
  logic        w_d0en, w_s1en, w_s2en;
  logic [63:0] w_d0imm, w_s1, w_s2imm;
  logic [9:0]  w_fun;
  logic [5:0]  w_itype;
  logic        w_illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  idu_stage #(.WIDTH(32), .INST_MAX(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .d0en(d0en), .s1en(s1en), .s2en(s2en),
    .d0imm(d0imm), .s1(s1), .s2imm(s2imm),
    .fun(fun), .itype(itype), .illegal(illegal)
  );

  idu_stage #(.WIDTH(64), .INST_MAX(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_inst(w_in_inst), .in_pc(w_in_pc),
    .out_valid(w_out_valid), .out_ready(1'b1), .out_pc(w_out_pc),
    .d0en(w_d0en), .s1en(w_s1en), .s2en(w_s2en),
    .d0imm(w_d0imm), .s1(w_s1), .s2imm(w_s2imm),
    .fun(w_fun), .itype(w_itype), .illegal(w_illegal)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Advance past the next rising edge; sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    tick();
  endtask

  initial begin
    // ---- reset ----
    #12;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_pc", out_pc, 0);
    rst_n = 1'b1;
    tick();

    // ---- addi x1,x2,-1 ----
    push(32'hFFF10093, 32'h100);
    in_valid = 1'b0;
    check_eq("addi_valid", out_valid, 1);
    check_eq("addi_itype", itype, 6'b000010);
    check_eq("addi_d0imm", d0imm, 1);
    check_eq("addi_s1", s1, 2);
    check_eq("addi_s2imm", s2imm, 32'hFFFFFFFF);
    check_eq("addi_fun", fun, 10'b000_1111111);
    check_eq("addi_illegal", illegal, 0);
    check_eq("addi_en", {d0en, s1en, s2en}, 3'b110);
    check_eq("addi_pc", out_pc, 32'h100);

    // ---- beq x1,x2,+16 ----
    push(32'h00208863, 32'h104);
    check_eq("beq_itype", itype, 6'b001000);
    check_eq("beq_en", {d0en, s1en, s2en}, 3'b011);
    check_eq("beq_d0imm", d0imm, 16);
    check_eq("beq_s1", s1, 1);
    check_eq("beq_s2imm", s2imm, 2);

    // ---- jal x1,+8 ----
    push(32'h008000EF, 32'h108);
    in_valid = 1'b0;
    check_eq("jal_itype", itype, 6'b100000);
    check_eq("jal_d0imm", d0imm, 1);
    check_eq("jal_s1en", s1en, 0);
    check_eq("jal_s1", s1, 0);
    check_eq("jal_s2imm", s2imm, 8);
    check_eq("jal_pc", out_pc, 32'h108);

    // ---- illegal encodings ----
    push(32'h00000000, 32'h10C);
    check_eq("ill0_illegal", illegal, 1);
    check_eq("ill0_itype", itype, 0);
    check_eq("ill0_en", {d0en, s1en, s2en}, 0);
    check_eq("ill0_data", {d0imm, s1, s2imm} == 96'd0, 1);
    check_eq("ill0_pc", out_pc, 32'h10C);
    push(32'h0000007F, 32'h110);
    in_valid = 1'b0;
    check_eq("ill7f_illegal", illegal, 1);
    check_eq("ill7f_itype", itype, 0);
    check_eq("ill7f_en", {d0en, s1en, s2en}, 0);
    tick();
    check_eq("idle_valid", out_valid, 0);

    // ---- stall: three back-to-back, only two accepted ----
    out_ready = 1'b0;
    push(32'hFFF10093, 32'h200);
    check_eq("stall_a_pc", out_pc, 32'h200);
    check_eq("stall_a_ready", in_ready, 1);
    push(32'h00208863, 32'h204);
    check_eq("stall_b_ready", in_ready, 0);
    check_eq("stall_b_pc", out_pc, 32'h200);
    push(32'h008000EF, 32'h208);
    check_eq("stall_c_ready", in_ready, 0);
    check_eq("stall_c_pc", out_pc, 32'h200);
    check_eq("stall_c_itype", itype, 6'b000010);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check_eq("drain_b_pc", out_pc, 32'h204);
    check_eq("drain_b_itype", itype, 6'b001000);
    check_eq("drain_ready", in_ready, 1);
    tick();
    check_eq("drain_c_absent", out_valid, 0);

    // ---- flush with both entries full and a concurrent input ----
    out_ready = 1'b0;
    push(32'hFFF10093, 32'h300);
    push(32'h00208863, 32'h304);
    check_eq("flush_pre_ready", in_ready, 0);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_inst  = 32'h008000EF;
    in_pc    = 32'h308;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("flush_valid", out_valid, 0);
    check_eq("flush_ready", in_ready, 1);
    check_eq("flush_pc", out_pc, 0);
    out_ready = 1'b1;
    tick();
    check_eq("flush_after1", out_valid, 0);
    tick();
    check_eq("flush_after2", out_valid, 0);

    // ---- asynchronous reset mid-stall ----
    out_ready = 1'b0;
    push(32'hFFF10093, 32'h400);
    push(32'h00208863, 32'h404);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", out_valid, 0);
    check_eq("arst_ready", in_ready, 1);
    check_eq("arst_pc", out_pc, 0);
    #2;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    check_eq("arst_after1", out_valid, 0);
    tick();
    check_eq("arst_after2", out_valid, 0);

    // ---- 64-bit lui x1,0x80000 ----
    w_in_valid = 1'b1;
    w_in_inst  = 32'h800000B7;
    w_in_pc    = 64'h1_0000_0000;
    tick();
    w_in_valid = 1'b0;
    check_eq("lui64_valid", w_out_valid, 1);
    check_eq("lui64_s2imm", w_s2imm, 64'hFFFFFFFF80000000);
    check_eq("lui64_itype", w_itype, 6'b010000);
    check_eq("lui64_d0imm", w_d0imm, 1);
    check_eq("lui64_s1en", w_s1en, 0);
    check_eq("lui64_pc", w_out_pc, 64'h1_0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
